// File: rtl/sub_bytes_engine_if.sv
// Block-level handshake bundle for sub_bytes_engine: input block channel, output block channel, busy.
// slave is the engine's view, master is the upstream/downstream driver's view.
interface sub_bytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_decrypt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport slave (
        input  in_valid, in_state, in_decrypt, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, in_decrypt, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes over one 16-byte state, LANES byte lookups per RUN cycle.
// Optional SUBBYTES_BLKCNT_EN adds a 16-bit wrapping count of completed output handshakes.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    sub_bytes_engine_if.slave   bus
`ifdef SUBBYTES_BLKCNT_EN
    ,
    output logic [15:0]         block_count
`endif
);

    localparam int ITER  = 16 / LANES;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Row r of each literal is table[r][0..15]; index 0 sits in the MSBs.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               mode;
    logic [127:0]       work;
    logic [127:0]       work_next;
    logic [127:0]       out_state_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    // Substitute the LANES bytes selected by the counter; byte 0 lives in bits [127:120].
    always_comb begin
        work_next = work;
        for (int k = 0; k < LANES; k++) begin
            work_next[8*(15 - (int'(cnt) * LANES + k)) +: 8] =
                sub_byte(work[8*(15 - (int'(cnt) * LANES + k)) +: 8], mode);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mode        <= 1'b0;
            work        <= '0;
            out_state_r <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work   <= bus.in_state;
                        mode   <= bus.in_decrypt;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work <= work_next;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        out_state_r <= work_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        // A waiting block is taken on the same edge as the output handshake.
                        if (bus.in_valid) begin
                            work  <= bus.in_state;
                            mode  <= bus.in_decrypt;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.out_state = out_state_r;
    assign bus.busy      = busy_r;

`ifdef SUBBYTES_BLKCNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block_count <= 16'h0000;
        end else if (out_valid_r && bus.out_ready) begin
            block_count <= block_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Randomized bench for sub_bytes_engine at LANES=4, 1 and 16 against an arithmetic GF(2^8) S-box model.
module tb_sub_bytes_engine;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sub_bytes_engine_if b4 ();
    sub_bytes_engine_if b1 ();
    sub_bytes_engine_if b16 ();

    logic         iv   [3];
    logic         idec [3];
    logic         ordy [3];
    logic [127:0] ist  [3];
    logic         ovl  [3];
    logic         irdy [3];
    logic         bsy  [3];
    logic [127:0] ost  [3];

    assign b4.in_valid    = iv[0];   assign b1.in_valid    = iv[1];   assign b16.in_valid    = iv[2];
    assign b4.in_decrypt  = idec[0]; assign b1.in_decrypt  = idec[1]; assign b16.in_decrypt  = idec[2];
    assign b4.out_ready   = ordy[0]; assign b1.out_ready   = ordy[1]; assign b16.out_ready   = ordy[2];
    assign b4.in_state    = ist[0];  assign b1.in_state    = ist[1];  assign b16.in_state    = ist[2];
    assign ovl[0]  = b4.out_valid;   assign ovl[1]  = b1.out_valid;   assign ovl[2]  = b16.out_valid;
    assign irdy[0] = b4.in_ready;    assign irdy[1] = b1.in_ready;    assign irdy[2] = b16.in_ready;
    assign bsy[0]  = b4.busy;        assign bsy[1]  = b1.busy;        assign bsy[2]  = b16.busy;
    assign ost[0]  = b4.out_state;   assign ost[1]  = b1.out_state;   assign ost[2]  = b16.out_state;

`ifdef SUBBYTES_BLKCNT_EN
    logic [15:0] bc [3];
    int exp_bc [3];
    sub_bytes_engine #(.LANES(4))  u_l4  (.clock(clock), .reset_n(reset_n), .bus(b4.slave),  .block_count(bc[0]));
    sub_bytes_engine #(.LANES(1))  u_l1  (.clock(clock), .reset_n(reset_n), .bus(b1.slave),  .block_count(bc[1]));
    sub_bytes_engine #(.LANES(16)) u_l16 (.clock(clock), .reset_n(reset_n), .bus(b16.slave), .block_count(bc[2]));
`else
    sub_bytes_engine #(.LANES(4))  u_l4  (.clock(clock), .reset_n(reset_n), .bus(b4.slave));
    sub_bytes_engine #(.LANES(1))  u_l1  (.clock(clock), .reset_n(reset_n), .bus(b1.slave));
    sub_bytes_engine #(.LANES(16)) u_l16 (.clock(clock), .reset_n(reset_n), .bus(b16.slave));
`endif

    int lat_of [3] = '{4, 16, 1};
    int errors = 0;
    int checks = 0;
    logic [7:0] m_sbox [256];
    logic [7:0] m_inv  [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            m_sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) m_inv[m_sbox[a]] = 8'(a);
    endtask

    function automatic logic [127:0] model(input logic [127:0] st, input logic dec);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) begin
            logic [7:0] b = st[8*(15-j) +: 8];
            r[8*(15-j) +: 8] = dec ? m_inv[b] : m_sbox[b];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (!ovl[idx] && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) check("timeout_out_valid", 0, 1);
    endtask

    // One complete transaction: accept, flip in_decrypt during RUN, wait for result, handshake.
    task automatic run_block(input int idx, input logic [127:0] st, input logic dec,
                             output logic [127:0] res, output int lat);
        int w = 0;
        while (!irdy[idx] && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) check("timeout_in_ready", 0, 1);
        iv[idx] = 1'b1; ist[idx] = st; idec[idx] = dec; ordy[idx] = 1'b1;
        tick();
        iv[idx] = 1'b0; idec[idx] = ~dec; ist[idx] = {$urandom, $urandom, $urandom, $urandom};
        wait_out(idx, lat);
        res = ost[idx];
        tick();
`ifdef SUBBYTES_BLKCNT_EN
        exp_bc[idx]++;
`endif
        check("out_valid_drop", ovl[idx], 0);
        check("out_state_persist", ost[idx], res);
    endtask

    task automatic xact(input string tag, input int idx, input logic [127:0] st, input logic dec);
        logic [127:0] res;
        int lat;
        run_block(idx, st, dec, res, lat);
        check({tag, "_data"}, res, model(st, dec));
        check({tag, "_lat"}, 128'(lat), 128'(lat_of[idx]));
    endtask

    initial begin
        logic [127:0] sta, stb, st;
        int lat;
        build_tables();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; idec[i] = 1'b0; ordy[i] = 1'b0; ist[i] = '0;
`ifdef SUBBYTES_BLKCNT_EN
            exp_bc[i] = 0;
`endif
        end
        #23;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", ovl[i], 0);
            check("rst_in_ready", irdy[i], 1);
            check("rst_busy", bsy[i], 0);
            check("rst_out_state", ost[i], 0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Directed vectors from the known S-box anchors.
        xact("enc_zero", 0, 128'h0, 1'b0);
        check("enc_zero_abs", ost[0], {16{8'h63}});
        xact("dec_63", 0, {16{8'h63}}, 1'b1);
        check("dec_63_abs", ost[0], 128'h0);
        xact("enc_53", 0, {8'h53, 120'h0}, 1'b0);
        check("enc_53_abs", ost[0], {8'hed, {15{8'h63}}});

        // Backpressure, then a new block taken on the output handshake edge.
        sta = {$urandom, $urandom, $urandom, $urandom};
        stb = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1; ist[0] = sta; idec[0] = 1'b0; ordy[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        wait_out(0, lat);
        check("bp_lat", 128'(lat), 128'd4);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", ovl[0], 1);
            check("bp_out_state", ost[0], model(sta, 1'b0));
            check("bp_in_ready", irdy[0], 0);
            check("bp_busy", bsy[0], 1);
            tick();
        end
        ordy[0] = 1'b1; iv[0] = 1'b1; ist[0] = stb; idec[0] = 1'b1;
        #1;
        check("bp_in_ready_release", irdy[0], 1);
        tick();
`ifdef SUBBYTES_BLKCNT_EN
        exp_bc[0]++;
`endif
        iv[0] = 1'b0; idec[0] = 1'b0;
        check("b2b_out_valid_fall", ovl[0], 0);
        check("b2b_busy", bsy[0], 1);
        check("b2b_hold_prev", ost[0], model(sta, 1'b0));
        wait_out(0, lat);
        check("b2b_lat", 128'(lat), 128'd4);
        check("b2b_data", ost[0], model(stb, 1'b1));
        tick();
`ifdef SUBBYTES_BLKCNT_EN
        exp_bc[0]++;
`endif

        // Full byte sweep in both modes on every lane configuration, then random blocks.
        for (int idx = 0; idx < 3; idx++) begin
            for (int blk = 0; blk < 16; blk++) begin
                for (int j = 0; j < 16; j++) st[8*(15-j) +: 8] = 8'(blk * 16 + j);
                xact("sweep_enc", idx, st, 1'b0);
                xact("sweep_dec", idx, st, 1'b1);
            end
            for (int r = 0; r < 10; r++)
                xact("rand", idx, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of RUN discards the block.
        iv[0] = 1'b1; ist[0] = {$urandom, $urandom, $urandom, $urandom}; idec[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        check("mid_busy", bsy[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", ovl[0], 0);
        check("arst_in_ready", irdy[0], 1);
        check("arst_busy", bsy[0], 0);
        check("arst_out_state", ost[0], 0);
`ifdef SUBBYTES_BLKCNT_EN
        for (int i = 0; i < 3; i++) begin
            check("arst_block_count", 128'(bc[i]), 0);
            exp_bc[i] = 0;
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_no_pulse", ovl[0], 0);
        end
        for (int r = 0; r < 3; r++)
            xact("post_rst", 0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));

`ifdef SUBBYTES_BLKCNT_EN
        for (int i = 0; i < 3; i++) check("block_count", 128'(bc[i]), 128'(exp_bc[i]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
